// File: rtl/puf_eval_sequencer.sv
// puf_eval_sequencer
//
// Drives a PUF through a sweep of consecutive challenges. Each challenge is
// evaluated NUM_EVALS times (reset -> enable/wait for done -> cool down), the
// eight response bits are majority-voted, and one voted response per
// challenge is handed to the host over a valid/ready handshake.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   start               begin a sweep (sampled in IDLE only)
//   base_challenge      first challenge of the sweep
//   num_challenges      sweep length, 0 means 256
//   busy                high while a sweep is in progress
//   puf_enable          PUF enable
//   puf_challenge       PUF challenge (holds last value when idle)
//   puf_reset           PUF reset, active-high
//   puf_done            PUF done, asynchronous to clk
//   puf_response        PUF response, stable while puf_done is high
//   resp_valid          voted response available
//   resp_ready          host accepts the response
//   resp_data           majority-voted response
//   resp_challenge      challenge that produced resp_data
//   resp_unstable       some bit was not unanimous across evaluations
//   run_done            one-cycle pulse when the sweep completes or aborts
//   timeout_err         sticky timeout flag, cleared by the next accepted start
//
// RST_CYCLES, COOL_CYCLES and TIMEOUT are assumed to be at least 1;
// NUM_EVALS is assumed odd and at least 1.

module puf_eval_sequencer #(
    parameter int unsigned NUM_EVALS   = 5,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned COOL_CYCLES = 8,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] base_challenge,
    input  logic [7:0] num_challenges,
    output logic       busy,
    output logic       puf_enable,
    output logic [7:0] puf_challenge,
    output logic       puf_reset,
    input  logic       puf_done,
    input  logic [7:0] puf_response,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic [7:0] resp_challenge,
    output logic       resp_unstable,
    output logic       run_done,
    output logic       timeout_err
);

    localparam int unsigned VcW     = $clog2(NUM_EVALS + 1);
    localparam int unsigned CntMax0 = (RST_CYCLES > COOL_CYCLES) ? RST_CYCLES : COOL_CYCLES;
    localparam int unsigned CntMax  = (TIMEOUT > CntMax0) ? TIMEOUT : CntMax0;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] CoolLast    = CntW'(COOL_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
    localparam logic [VcW-1:0]  EvalsLast   = VcW'(NUM_EVALS - 1);
    localparam logic [VcW-1:0]  VcAll       = VcW'(NUM_EVALS);
    localparam logic [VcW-1:0]  VcHalf      = VcW'(NUM_EVALS / 2);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StEval,
        StCool,
        StDecide,
        StOutput
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [VcW-1:0]    eval_idx_q, eval_idx_d;
    logic [VcW-1:0]    vc_q [8];
    logic [VcW-1:0]    vc_d [8];
    logic [7:0]        cur_chal_q, cur_chal_d;
    logic [8:0]        remaining_q, remaining_d;
    logic              timeout_err_q, timeout_err_d;
    logic              run_done_q, run_done_d;
    logic [7:0]        resp_data_q, resp_data_d;
    logic [7:0]        resp_chal_q, resp_chal_d;
    logic              resp_unstable_q, resp_unstable_d;
    logic [7:0]        puf_chal_q;
    logic              busy_q, puf_enable_q, puf_reset_q, resp_valid_q;
    logic              done_meta_q, done_s_q;

    // Two-flop synchronizer for the asynchronous PUF done signal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
        end else begin
            done_meta_q <= puf_done;
            done_s_q    <= done_meta_q;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        eval_idx_d      = eval_idx_q;
        vc_d            = vc_q;
        cur_chal_d      = cur_chal_q;
        remaining_d     = remaining_q;
        timeout_err_d   = timeout_err_q;
        run_done_d      = 1'b0;
        resp_data_d     = resp_data_q;
        resp_chal_d     = resp_chal_q;
        resp_unstable_d = resp_unstable_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_chal_d    = base_challenge;
                    remaining_d   = (num_challenges == 8'd0) ? 9'd256 : {1'b0, num_challenges};
                    timeout_err_d = 1'b0;
                    for (int i = 0; i < 8; i++) vc_d[i] = '0;
                    eval_idx_d    = '0;
                    cnt_d         = '0;
                    state_d       = StArm;
                end
            end

            StArm: begin
                if (cnt_q == RstLast) begin
                    cnt_d   = '0;
                    state_d = StEval;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StEval: begin
                if (done_s_q) begin
                    for (int i = 0; i < 8; i++) vc_d[i] = vc_q[i] + VcW'(puf_response[i]);
                    cnt_d   = '0;
                    state_d = StCool;
                end else if (cnt_q == TimeoutLast) begin
                    // Abandon the whole sweep; this challenge produces no response.
                    timeout_err_d = 1'b1;
                    run_done_d    = 1'b1;
                    cnt_d         = '0;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StCool: begin
                if (cnt_q == CoolLast) begin
                    cnt_d      = '0;
                    eval_idx_d = eval_idx_q + VcW'(1);
                    state_d    = (eval_idx_q == EvalsLast) ? StDecide : StArm;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDecide: begin
                resp_unstable_d = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    resp_data_d[i] = (vc_q[i] > VcHalf);
                    if (vc_q[i] != '0 && vc_q[i] != VcAll) resp_unstable_d = 1'b1;
                end
                resp_chal_d = cur_chal_q;
                state_d     = StOutput;
            end

            StOutput: begin
                // resp_valid is high for the whole of this state, so ready alone
                // marks the transfer cycle.
                if (resp_ready) begin
                    remaining_d = remaining_q - 9'd1;
                    cur_chal_d  = cur_chal_q + 8'd1;
                    for (int i = 0; i < 8; i++) vc_d[i] = '0;
                    eval_idx_d  = '0;
                    cnt_d       = '0;
                    if (remaining_q == 9'd1) begin
                        run_done_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StArm;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly with
    // the state and carry no decode glitches to the PUF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            eval_idx_q      <= '0;
            vc_q            <= '{default: '0};
            cur_chal_q      <= '0;
            remaining_q     <= '0;
            timeout_err_q   <= 1'b0;
            run_done_q      <= 1'b0;
            resp_data_q     <= '0;
            resp_chal_q     <= '0;
            resp_unstable_q <= 1'b0;
            puf_chal_q      <= '0;
            busy_q          <= 1'b0;
            puf_enable_q    <= 1'b0;
            puf_reset_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            eval_idx_q      <= eval_idx_d;
            vc_q            <= vc_d;
            cur_chal_q      <= cur_chal_d;
            remaining_q     <= remaining_d;
            timeout_err_q   <= timeout_err_d;
            run_done_q      <= run_done_d;
            resp_data_q     <= resp_data_d;
            resp_chal_q     <= resp_chal_d;
            resp_unstable_q <= resp_unstable_d;
            busy_q          <= (state_d != StIdle);
            puf_enable_q    <= (state_d == StEval);
            puf_reset_q     <= (state_d == StArm);
            resp_valid_q    <= (state_d == StOutput);
            if (state_d == StArm) puf_chal_q <= cur_chal_d;
        end
    end

    assign busy           = busy_q;
    assign puf_enable     = puf_enable_q;
    assign puf_challenge  = puf_chal_q;
    assign puf_reset      = puf_reset_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_challenge = resp_chal_q;
    assign resp_unstable  = resp_unstable_q;
    assign run_done       = run_done_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Testbench for puf_eval_sequencer: a behavioural PUF model answers each
// enable with a chosen or random response; every response handed out is
// logged, and the expected voted result per challenge is recomputed from
// that log by counting ones per bit.

module tb_puf_eval_sequencer;

    localparam int NUM_EVALS   = 5;
    localparam int RST_CYCLES  = 4;
    localparam int COOL_CYCLES = 8;
    localparam int TIMEOUT     = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_challenge = 8'h00;
    logic [7:0] num_challenges = 8'h00;
    logic       busy, puf_enable, puf_reset, resp_valid, resp_unstable, run_done, timeout_err;
    logic [7:0] puf_challenge, resp_data, resp_challenge;
    logic       puf_done = 1'b0;
    logic [7:0] puf_response = 8'h00;
    logic       resp_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    puf_eval_sequencer #(
        .NUM_EVALS  (NUM_EVALS),
        .RST_CYCLES (RST_CYCLES),
        .COOL_CYCLES(COOL_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_challenge(base_challenge),
        .num_challenges(num_challenges),
        .busy          (busy),
        .puf_enable    (puf_enable),
        .puf_challenge (puf_challenge),
        .puf_reset     (puf_reset),
        .puf_done      (puf_done),
        .puf_response  (puf_response),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_challenge(resp_challenge),
        .resp_unstable (resp_unstable),
        .run_done      (run_done),
        .timeout_err   (timeout_err)
    );

    // PUF model. Modes: 0 fixed value, 1 scripted sequence, 2 random, 3 never done.
    int         puf_mode  = 0;
    int         puf_delay = 10;
    logic [7:0] puf_fixed = 8'hA5;
    logic [7:0] puf_seq[$];
    logic [7:0] puf_v;
    int         en_cnt = 0;
    logic [7:0] served[$];
    logic [7:0] served_chal[$];

    always @(posedge clk) begin
        if (!puf_enable) begin
            en_cnt   <= 0;
            puf_done <= 1'b0;
        end else begin
            en_cnt <= en_cnt + 1;
            if (en_cnt + 1 == puf_delay && puf_mode != 3) begin
                if (puf_mode == 1 && puf_seq.size() > 0) puf_v = puf_seq.pop_front();
                else if (puf_mode == 2) puf_v = 8'($urandom);
                else puf_v = puf_fixed;
                puf_response <= puf_v;
                puf_done     <= 1'b1;
                served.push_back(puf_v);
                served_chal.push_back(puf_challenge);
            end
        end
    end

    // Host side: optional random ready.
    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 resp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor, sampling on the falling edge.
    logic [7:0] got_data[$];
    logic [7:0] got_chal[$];
    logic       got_unst[$];
    int   run_done_cnt = 0, valid_cycles = 0;
    int   rst_pulses = 0, rst_bad_len = 0, rst_len = 0;
    int   en_len = 0, last_en_len = 0;
    logic prev_rst = 1'b0, prev_en = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            rst_len  = 0;
            en_len   = 0;
            prev_rst = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (resp_valid && resp_ready) begin
                got_data.push_back(resp_data);
                got_chal.push_back(resp_challenge);
                got_unst.push_back(resp_unstable);
            end
            if (run_done) run_done_cnt++;
            if (resp_valid) valid_cycles++;
            if (puf_reset) rst_len++;
            else if (prev_rst) begin
                rst_pulses++;
                if (rst_len != RST_CYCLES) rst_bad_len++;
                rst_len = 0;
            end
            if (puf_enable) en_len++;
            else if (prev_en) begin
                last_en_len = en_len;
                en_len      = 0;
            end
            prev_rst = puf_reset;
            prev_en  = puf_enable;
        end
    end

    // Reference vote for the k-th challenge of the current log.
    function automatic void model_vote(input int k, output logic [7:0] d, output logic u);
        int ones;
        d = 8'h00;
        u = 1'b0;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int j = 0; j < NUM_EVALS; j++) ones += int'(served[k * NUM_EVALS + j][b]);
            d[b] = (2 * ones > NUM_EVALS);
            if (ones != 0 && ones != NUM_EVALS) u = 1'b1;
        end
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        served.delete();
        served_chal.delete();
        got_data.delete();
        got_chal.delete();
        got_unst.delete();
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] n);
        @(posedge clk);
        #1;
        base_challenge = b;
        num_challenges = n;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_run_done(input int bound, input int base_cnt, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (run_done_cnt > base_cnt) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycles(3);
        n_checks++;
        if ({busy, puf_enable, puf_reset, resp_valid, run_done, timeout_err, resp_unstable}
            !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {busy, puf_enable, puf_reset, resp_valid, run_done, timeout_err,
                      resp_unstable});
        end
        n_checks++;
        if ({resp_data, resp_challenge, puf_challenge} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 000000",
                     {resp_data, resp_challenge, puf_challenge});
        end
        reset = 1'b1;
        cycles(2);
    endtask

    task automatic test_basic();
        bit timed_out;
        int rd0;
        clear_logs();
        puf_mode   = 0;
        puf_fixed  = 8'hA5;
        puf_delay  = 10;
        resp_ready = 1'b1;
        rd0        = run_done_cnt;
        do_start(8'h10, 8'd1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        wait_run_done(3000, rd0, timed_out);
        cycles(3);
        n_checks++;
        if (timed_out !== 1'b0 || got_data.size() != 1) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d beats (timeout %0d) expected 1",
                     got_data.size(), timed_out);
        end else begin
            n_checks++;
            if ({got_data[0], got_chal[0], got_unst[0]} !== {8'hA5, 8'h10, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_beat: got data %h chal %h unst %b expected A5 10 0",
                         got_data[0], got_chal[0], got_unst[0]);
            end
        end
        n_checks++;
        if (run_done_cnt - rd0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got run_done %0d busy %b expected 1 0",
                     run_done_cnt - rd0, busy);
        end
    endtask

    task automatic test_unstable();
        bit timed_out;
        int rd0;
        logic [7:0] b;
        logic [7:0] md;
        logic mu;
        clear_logs();
        puf_mode = 1;
        puf_seq  = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
        b        = 8'($urandom);
        rd0      = run_done_cnt;
        do_start(b, 8'd1);
        wait_run_done(3000, rd0, timed_out);
        model_vote(0, md, mu);
        n_checks++;
        if (timed_out !== 1'b0 || got_data.size() != 1 || served.size() != NUM_EVALS) begin
            n_fail++;
            $display("FAIL unstable_beats: got %0d beats %0d evals expected 1 %0d",
                     got_data.size(), served.size(), NUM_EVALS);
        end else begin
            n_checks++;
            if ({got_data[0], got_unst[0], got_chal[0]} !== {8'hFF, 1'b1, b}
                || {md, mu} !== {8'hFF, 1'b1}) begin
                n_fail++;
                $display("FAIL unstable_beat: got %h %b %h model %h %b expected FF 1 %h",
                         got_data[0], got_unst[0], got_chal[0], md, mu, b);
            end
        end
    endtask

    task automatic test_wrap();
        bit timed_out;
        int rd0, rp0, bad0, bad;
        logic [7:0] md;
        logic mu;
        clear_logs();
        puf_mode  = 2;
        puf_delay = 4;
        rd0       = run_done_cnt;
        rp0       = rst_pulses;
        bad0      = rst_bad_len;
        do_start(8'hFE, 8'd3);
        wait_run_done(6000, rd0, timed_out);
        cycles(2);
        n_checks++;
        if (rst_pulses - rp0 != 3 * NUM_EVALS || rst_bad_len != bad0) begin
            n_fail++;
            $display("FAIL wrap_rst_pulses: got %0d pulses %0d bad expected %0d 0",
                     rst_pulses - rp0, rst_bad_len - bad0, 3 * NUM_EVALS);
        end
        n_checks++;
        if (timed_out !== 1'b0 || got_data.size() != 3 || served.size() != 3 * NUM_EVALS) begin
            n_fail++;
            $display("FAIL wrap_beats: got %0d beats expected 3", got_data.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 3; k++) begin
                model_vote(k, md, mu);
                if (got_chal[k] !== 8'(8'hFE + k) || got_data[k] !== md || got_unst[k] !== mu)
                    bad++;
                for (int j = 0; j < NUM_EVALS; j++)
                    if (served_chal[k * NUM_EVALS + j] !== 8'(8'hFE + k)) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL wrap_content: got %0d bad fields (chals %h %h %h) expected 0",
                         bad, got_chal[0], got_chal[1], got_chal[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit timed_out;
        int rd0, n0, unstable_cnt;
        logic [7:0] sd, sc;
        logic su;
        logic [7:0] md;
        logic mu;
        clear_logs();
        puf_mode   = 2;
        puf_delay  = 3;
        resp_ready = 1'b0;
        rd0        = run_done_cnt;
        do_start(8'($urandom), 8'd2);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycles(1);
            if (resp_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        n_checks++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_valid: got no resp_valid expected valid");
        end
        sd = resp_data;
        sc = resp_challenge;
        su = resp_unstable;
        unstable_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (resp_valid !== 1'b1 || {resp_data, resp_challenge, resp_unstable} !== {sd, sc, su}
                || puf_reset !== 1'b0 || puf_enable !== 1'b0) unstable_cnt++;
        end
        n_checks++;
        if (unstable_cnt != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d disturbed cycles expected 0", unstable_cnt);
        end
        n0         = got_data.size();
        resp_ready = 1'b1;
        cycles(1);
        resp_ready = 1'b0;
        cycles(4);
        n_checks++;
        if (got_data.size() != n0 + 1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_one_transfer: got %0d transfers valid %b expected 1 0",
                     got_data.size() - n0, resp_valid);
        end
        resp_ready = 1'b1;
        wait_run_done(3000, rd0, timed_out);
        n_checks++;
        if (timed_out !== 1'b0 || got_data.size() != 2) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d beats expected 2", got_data.size());
        end else begin
            model_vote(0, md, mu);
            n_checks++;
            if ({got_data[0], got_chal[0], got_unst[0]} !== {md, sc, mu}
                || {sd, su} !== {md, mu} || got_chal[1] !== 8'(sc + 1)) begin
                n_fail++;
                $display("FAIL bp_content: got %h %h %b expected %h %h %b",
                         got_data[0], got_chal[0], got_unst[0], md, sc, mu);
            end
        end
    endtask

    task automatic test_timeout();
        bit timed_out;
        int rd0, vc0;
        clear_logs();
        puf_mode   = 3;
        resp_ready = 1'b1;
        rd0        = run_done_cnt;
        vc0        = valid_cycles;
        do_start(8'h33, 8'd2);
        wait_run_done(TIMEOUT + 200, rd0, timed_out);
        cycles(2);
        n_checks++;
        if (timed_out !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag: got timeout_err %b busy %b (wait expired %0d) expected 1 0",
                     timeout_err, busy, timed_out);
        end
        n_checks++;
        if (last_en_len != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d enable cycles expected %0d", last_en_len, TIMEOUT);
        end
        n_checks++;
        if (valid_cycles != vc0 || got_data.size() != 0 || run_done_cnt - rd0 != 1) begin
            n_fail++;
            $display("FAIL timeout_no_resp: got %0d valid cycles %0d run_done expected 0 1",
                     valid_cycles - vc0, run_done_cnt - rd0);
        end
        puf_mode  = 0;
        puf_fixed = 8'h3C;
        rd0       = run_done_cnt;
        do_start(8'h44, 8'd1);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
        wait_run_done(3000, rd0, timed_out);
        n_checks++;
        if (timed_out !== 1'b0 || got_data.size() != 1 || got_data[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL timeout_recover: got %0d beats expected 1 of 3C", got_data.size());
        end
    endtask

    task automatic test_reset_mid();
        bit timed_out;
        int rd0, bad;
        logic [7:0] b;
        logic [7:0] md;
        logic mu;
        clear_logs();
        puf_mode  = 2;
        puf_delay = 6;
        rd0       = run_done_cnt;
        do_start(8'h20, 8'd3);
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycles(1);
            if (puf_enable) begin
                timed_out = 1'b0;
                break;
            end
        end
        cycles(2);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (timed_out !== 1'b0 || {busy, puf_enable, puf_reset, resp_valid, run_done, timeout_err,
            resp_unstable, resp_data, resp_challenge, puf_challenge} !== 31'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h (eval reached %0d) expected 0",
                     {busy, puf_enable, puf_reset, resp_valid, run_done, timeout_err,
                      resp_unstable, resp_data, resp_challenge, puf_challenge}, !timed_out);
        end
        cycles(3);
        reset = 1'b1;
        cycles(3);
        n_checks++;
        if (run_done_cnt != rd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d run_done busy %b expected 0 0",
                     run_done_cnt - rd0, busy);
        end
        clear_logs();
        b   = 8'($urandom);
        rd0 = run_done_cnt;
        do_start(b, 8'd2);
        wait_run_done(4000, rd0, timed_out);
        n_checks++;
        if (timed_out !== 1'b0 || got_data.size() != 2 || served.size() != 2 * NUM_EVALS) begin
            n_fail++;
            $display("FAIL midreset_restart: got %0d beats expected 2", got_data.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 2; k++) begin
                model_vote(k, md, mu);
                if (got_chal[k] !== 8'(b + k) || got_data[k] !== md || got_unst[k] !== mu) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL midreset_content: got %0d bad beats expected 0", bad);
            end
        end
    endtask

    task automatic test_full_sweep();
        bit timed_out;
        int rd0, bad;
        logic [7:0] b;
        logic [7:0] md;
        logic mu;
        clear_logs();
        puf_mode   = 2;
        puf_delay  = int'($urandom_range(1, 4));
        b          = 8'($urandom);
        rd0        = run_done_cnt;
        rand_ready = 1'b1;
        do_start(b, 8'd0);
        wait_run_done(60000, rd0, timed_out);
        rand_ready = 1'b0;
        cycles(2);
        resp_ready = 1'b1;
        n_checks++;
        if (timed_out !== 1'b0 || got_data.size() != 256 || served.size() != 256 * NUM_EVALS) begin
            n_fail++;
            $display("FAIL full_beats: got %0d beats %0d evals expected 256 %0d",
                     got_data.size(), served.size(), 256 * NUM_EVALS);
        end else begin
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                model_vote(k, md, mu);
                if (got_chal[k] !== 8'(b + k) || got_data[k] !== md || got_unst[k] !== mu) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL full_content: got %0d bad beats expected 0", bad);
            end
        end
        n_checks++;
        if (run_done_cnt - rd0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_end: got %0d run_done busy %b expected 1 0",
                     run_done_cnt - rd0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unstable();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_full_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_eval_sequencer.md
Name: puf_eval_sequencer

Overview:
Control stage directly upstream and downstream of the PUF top-level. It drives the PUF's enable, challenge and reset inputs, and waits on done_sig. It then captures the 8-bit response and repeats each challenge NUM_EVALS times, majority-voting every bit. A sweep of consecutive challenges is run, and one voted response per challenge is delivered to the host over a valid/ready handshake.

Parameters:
NUM_EVALS, 5, evaluations per challenge; must be odd and ≥1.
RST_CYCLES, 4, cycles puf_reset is held high before each evaluation.
COOL_CYCLES, 8, cycles puf_enable is held low after each evaluation.
TIMEOUT, 4096, max cycles in EVAL waiting for synchronized done.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  begin sweep; sampled in IDLE only
base_challenge  input  8  first challenge of the sweep
num_challenges  input  8  sweep length; 0 means 256
busy  output  1  high from start acceptance until the sweep ends
puf_enable  output  1  to PUF enable
puf_challenge  output  8  to PUF challenge
puf_reset  output  1  to PUF reset, active-high
puf_done  input  1  from PUF done_sig; asynchronous
puf_response  input  8  from PUF response; stable while puf_done is high
resp_valid  output  1  voted response available
resp_ready  input  1  host accepts response
resp_data  output  8  majority-voted response
resp_challenge  output  8  challenge that produced resp_data
resp_unstable  output  1  some bit was not unanimous across evaluations
run_done  output  1  one-cycle pulse when the sweep completes or aborts
timeout_err  output  1  sticky flag; cleared on the next accepted start

Behaviour:
- Reset (reset=0, asynchronous) clears all state immediately:
  - state=IDLE.
  - All outputs 0: busy, puf_enable, puf_reset, resp_valid, run_done, timeout_err, resp_data, resp_challenge, resp_unstable and puf_challenge.
  - Vote counters and the done synchronizer are cleared.
  - Reset mid-sweep abandons the sweep and does not pulse run_done.
- puf_done passes through a 2-flop synchronizer (done_s). Detection latency is 2 cycles.
- States: IDLE, ARM, EVAL, COOL, DECIDE, OUTPUT.
- IDLE, on start=1:
  - Latch cur_chal=base_challenge and remaining=num_challenges (0 maps to 256, 9-bit counter).
  - Clear timeout_err, clear vote counters, set eval_idx=0.
  - busy=1, next state ARM.
  - start is ignored in all other states.
- ARM:
  - puf_reset=1, puf_enable=0, puf_challenge=cur_chal, for exactly RST_CYCLES cycles.
  - Then go to EVAL.
- EVAL:
  - puf_reset=0, puf_enable=1, challenge held.
  - On the first cycle with done_s=1, capture puf_response. Each per-bit counter vc[i] (width clog2(NUM_EVALS+1)) increments where the bit is 1; then go to COOL.
  - If TIMEOUT cycles elapse without done_s: set timeout_err=1, drop puf_enable, pulse run_done, busy=0, go to IDLE. No response is emitted for that challenge.
- COOL:
  - puf_enable=0 for COOL_CYCLES cycles.
  - Then eval_idx++. If eval_idx==NUM_EVALS go to DECIDE, else go to ARM.
- DECIDE (1 cycle):
  - resp_data[i] = (vc[i] > NUM_EVALS/2).
  - resp_unstable = any vc[i] not in {0, NUM_EVALS}.
  - resp_challenge = cur_chal.
  - Go to OUTPUT.
- OUTPUT:
  - resp_valid=1; resp_data, resp_challenge and resp_unstable stay stable until the handshake.
  - Transfer occurs on a cycle with resp_valid & resp_ready. On the next cycle resp_valid=0.
  - Then remaining--, cur_chal = cur_chal+1 (mod 256, 0xFF wraps to 0x00), clear vote counters, eval_idx=0.
  - If remaining reaches 0: one-cycle run_done pulse, busy=0, go to IDLE. Otherwise go to ARM.
  - resp_ready while resp_valid=0 has no effect.
- Latency per challenge, with ready held high: NUM_EVALS*(RST_CYCLES + t_eval + COOL_CYCLES) + 2. t_eval includes the 2-cycle synchronizer delay.
- puf_done already high on EVAL entry: captured after synchronizer latency. This is legal, because ARM holds the PUF in reset, so a stale done counts as a design fault in the PUF, not here.
- puf_challenge holds the last value in IDLE.

Test Plan:
- Model PUF returns 0xA5 with done 10 cycles after enable. start, base=0x10, num=1, ready=1 → one beat: resp_data=0xA5, resp_challenge=0x10, resp_unstable=0; run_done pulses; busy falls.
- Model returns 0xFF,0xFF,0x00,0xFF,0x00 across 5 evaluations → resp_data=0xFF, resp_unstable=1.
- base=0xFE, num=3 → challenges 0xFE, 0xFF, 0x00 in that order; puf_reset pulses exactly 15 times, each RST_CYCLES=4 long.
- resp_ready held low for 50 cycles in OUTPUT → resp_valid and data stay stable, no ARM entry; after ready=1, exactly one transfer occurs.
- puf_done stuck low → timeout_err=1 after 4096 EVAL cycles, run_done pulse, no resp_valid; a new start clears timeout_err.
- Assert reset low mid-EVAL → all outputs are 0 immediately with no run_done; start after release begins a clean sweep. Also num=0 → 256 responses.
